// File: rtl/sram_responder_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sram_responder_pkg : shared types and defaults for the SRAM bus responder
// Revision: 1.0
// ----------------------------------------------------------------------------
package sram_responder_pkg;

    localparam int c_default_mem_depth   = 4096;
    localparam int c_default_wait_cycles = 1;
    localparam int c_wait_cnt_width      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } sram_state_type;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
    } sram_req_type;

    function automatic logic is_write(input logic [3:0] wstrb);
        return |wstrb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_responder_array.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sram_array : word-organised single-port SRAM with byte-write enables, no reset
// Revision: 1.0
// ----------------------------------------------------------------------------
module sram_array #(
    parameter int MEM_DEPTH  = 4096,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [3:0]            we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] r_mem [MEM_DEPTH];

    // Read-before-write: a write cycle returns the old word, which the
    // responder discards anyway.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata <= r_mem[addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sram_responder : memory-bus responder with wait states, byte writes, range check
// Revision: 1.0
// ----------------------------------------------------------------------------
module sram_responder
    import sram_responder_pkg::*;
#(
    parameter int          MEM_DEPTH   = c_default_mem_depth,
    parameter int          WAIT_CYCLES = c_default_wait_cycles,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memory_valid,
    input  logic        memory_instr,
    input  logic [31:0] memory_addr,
    input  logic [31:0] memory_wdata,
    input  logic [3:0]  memory_wstrb,
    output logic [31:0] memory_rdata,
    output logic        memory_ready,
    output logic        memory_error
);

    localparam int ADDR_WIDTH = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [c_wait_cnt_width-1:0] c_wait_load = c_wait_cnt_width'(WAIT_CYCLES);

    sram_state_type              r_state;
    sram_state_type              w_state_next;
    logic [c_wait_cnt_width-1:0] r_wait_cnt;
    logic [c_wait_cnt_width-1:0] w_wait_cnt_next;
    sram_req_type                r_req;
    sram_req_type                w_req_next;

    logic        r_ready;
    logic        r_error;
    logic        r_rd_sel;
    logic [31:0] w_offset;
    logic [31:0] w_index;
    logic        w_in_range;
    logic        w_fault;
    logic        w_enter_resp;
    logic        w_mem_en;
    logic [3:0]  w_mem_we;
    logic [31:0] w_mem_rdata;

    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        w_req_next      = r_req;
        case (r_state)
            IDLE: begin
                if (memory_valid) begin
                    w_req_next.addr  = memory_addr;
                    w_req_next.wdata = memory_wdata;
                    w_req_next.wstrb = memory_wstrb;
                    w_req_next.instr = memory_instr;
                    w_wait_cnt_next  = c_wait_load;
                    w_state_next     = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (r_wait_cnt <= 1) begin
                    w_state_next = RESP;
                end else begin
                    w_wait_cnt_next = r_wait_cnt - 1'b1;
                end
            end
            RESP: begin
                w_state_next    = IDLE;
                w_wait_cnt_next = '0;
            end
            default: begin
                w_state_next    = IDLE;
                w_wait_cnt_next = '0;
            end
        endcase
    end

    // The array is accessed on the edge that enters RESP, using the request
    // that will be held there; with zero wait states that is the incoming one.
    assign w_offset     = w_req_next.addr - BASE_ADDR;
    assign w_index      = w_offset >> 2;
    assign w_in_range   = (w_index < 32'(MEM_DEPTH));
    assign w_fault      = !w_in_range || (w_req_next.instr && is_write(w_req_next.wstrb));
    assign w_enter_resp = rst && (w_state_next == RESP);
    assign w_mem_en     = w_enter_resp && !w_fault;
    assign w_mem_we     = w_mem_en ? w_req_next.wstrb : 4'b0000;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
            r_req      <= '0;
            r_ready    <= 1'b0;
            r_error    <= 1'b0;
            r_rd_sel   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
            r_req      <= w_req_next;
            r_ready    <= w_enter_resp;
            r_error    <= w_enter_resp && w_fault;
            r_rd_sel   <= w_mem_en && !is_write(w_req_next.wstrb);
        end
    end

    sram_array #(
        .MEM_DEPTH  (MEM_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .en    (w_mem_en),
        .we    (w_mem_we),
        .addr  (w_index[ADDR_WIDTH-1:0]),
        .wdata (w_req_next.wdata),
        .rdata (w_mem_rdata)
    );

    assign memory_rdata = r_rd_sel ? w_mem_rdata : 32'h0;
    assign memory_ready = r_ready;
    assign memory_error = r_error;

endmodule
`default_nettype wire

// File: tb/tb_sram_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sram_responder : scoreboard bench over three responder configurations
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_sram_responder;

    // Instance 0: WAIT=1 defaults; 1: WAIT=0, BASE 0x1000, 1K words; 2: WAIT=4, 256 words
    logic            clk = 1'b0;
    logic [2:0]      rst;
    logic [2:0]      valid;
    logic [2:0]      instr;
    logic [2:0]      rdy;
    logic [2:0]      errs;
    logic [2:0][31:0] addr;
    logic [2:0][31:0] wdata;
    logic [2:0][31:0] rdat;
    logic [2:0][3:0]  wstrb;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int resp_count [3] = '{0, 0, 0};
    int resp_cyc   [3] = '{0, 0, 0};
    bit mon_en = 1'b0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_responder #(.MEM_DEPTH(4096), .WAIT_CYCLES(1), .BASE_ADDR(32'h0)) u_dut_w1 (
        .clk(clk), .rst(rst[0]), .memory_valid(valid[0]), .memory_instr(instr[0]),
        .memory_addr(addr[0]), .memory_wdata(wdata[0]), .memory_wstrb(wstrb[0]),
        .memory_rdata(rdat[0]), .memory_ready(rdy[0]), .memory_error(errs[0]));

    sram_responder #(.MEM_DEPTH(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h1000)) u_dut_w0 (
        .clk(clk), .rst(rst[1]), .memory_valid(valid[1]), .memory_instr(instr[1]),
        .memory_addr(addr[1]), .memory_wdata(wdata[1]), .memory_wstrb(wstrb[1]),
        .memory_rdata(rdat[1]), .memory_ready(rdy[1]), .memory_error(errs[1]));

    sram_responder #(.MEM_DEPTH(256), .WAIT_CYCLES(4), .BASE_ADDR(32'h0)) u_dut_w4 (
        .clk(clk), .rst(rst[2]), .memory_valid(valid[2]), .memory_instr(instr[2]),
        .memory_addr(addr[2]), .memory_wdata(wdata[2]), .memory_wstrb(wstrb[2]),
        .memory_rdata(rdat[2]), .memory_ready(rdy[2]), .memory_error(errs[2]));

    function automatic int lat_of(input int k);
        case (k)
            0:       return 1;
            1:       return 0;
            default: return 4;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push(input int k, input logic [31:0] rd, input logic e);
        exp_t x;
        x.rdata = rd;
        x.err   = e;
        x.acc   = cyc;
        x.lat   = lat_of(k);
        case (k)
            0:       q0.push_back(x);
            1:       q1.push_back(x);
            default: q2.push_back(x);
        endcase
    endtask

    task automatic monitor();
        exp_t e;
        bit   have;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                for (int k = 0; k < 3; k++) begin
                    if (rdy[k]) begin
                        have = 1'b0;
                        case (k)
                            0: if (q0.size() > 0) begin have = 1'b1; e = q0.pop_front(); end
                            1: if (q1.size() > 0) begin have = 1'b1; e = q1.pop_front(); end
                            default: if (q2.size() > 0) begin have = 1'b1; e = q2.pop_front(); end
                        endcase
                        resp_count[k]++;
                        resp_cyc[k] = cyc;
                        chk($sformatf("dut%0d_expected_pending", k), 32'(have), 32'd1);
                        if (have) begin
                            chk($sformatf("dut%0d_rdata", k), rdat[k], e.rdata);
                            chk($sformatf("dut%0d_error", k), 32'(errs[k]), 32'(e.err));
                            chk($sformatf("dut%0d_latency", k), 32'(cyc - e.acc), 32'(e.lat));
                        end
                    end else begin
                        chk($sformatf("dut%0d_idle_outputs", k), rdat[k] | 32'(errs[k]), 32'h0);
                    end
                end
            end
        end
    endtask

    task automatic access(input int k, input logic ins, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] ws,
                          input logic [31:0] erd, input logic eerr);
        int start;
        @(negedge clk);
        valid[k] = 1'b1;
        instr[k] = ins;
        addr[k]  = a;
        wdata[k] = wd;
        wstrb[k] = ws;
        start    = resp_count[k];
        @(posedge clk);
        #1;
        push(k, erd, eerr);
        // Garbage after accept must not disturb the captured request.
        valid[k] = 1'b0;
        instr[k] = 1'($urandom);
        addr[k]  = $urandom;
        wdata[k] = $urandom;
        wstrb[k] = 4'($urandom);
        for (int i = 0; i < 40 && resp_count[k] == start; i++) @(posedge clk);
        chk($sformatf("dut%0d_response_count", k), 32'(resp_count[k] - start), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] b2b_addr [3] = '{32'h1100, 32'h1104, 32'h1108};
        logic [31:0] b2b_data [3] = '{32'h11110000, 32'h22220000, 32'h33330000};
        int          t        [3];
        int          base;
        int          start;

        rst   = 3'b000;
        valid = '0;
        instr = '0;
        addr  = '0;
        wdata = '0;
        wstrb = '0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_ready%0d", k), 32'(rdy[k]), 32'h0);
            chk($sformatf("reset_rdata%0d", k), rdat[k], 32'h0);
            chk($sformatf("reset_error%0d", k), 32'(errs[k]), 32'h0);
        end
        rst    = 3'b111;
        mon_en = 1'b1;

        // Instance 0: basic, byte lanes, range, fetch-write
        access(0, 0, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0);
        access(0, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0);
        access(0, 0, 32'h20, 32'hFFFFFFFF, 4'hF, 32'h0, 0);
        access(0, 0, 32'h20, 32'h00AA0000, 4'b0100, 32'h0, 0);
        access(0, 0, 32'h20, 32'h0, 4'h0, 32'hFFAAFFFF, 0);
        access(0, 0, 32'h22, 32'h0, 4'h0, 32'hFFAAFFFF, 0);
        access(0, 0, 32'h0, 32'h12345678, 4'hF, 32'h0, 0);
        access(0, 0, 32'h4000, 32'h0, 4'h0, 32'h0, 1);
        access(0, 0, 32'h4000, 32'hCAFEF00D, 4'hF, 32'h0, 1);
        access(0, 0, 32'h0, 32'h0, 4'h0, 32'h12345678, 0);
        access(0, 0, 32'h8, 32'h0BADF00D, 4'hF, 32'h0, 0);
        access(0, 1, 32'h8, 32'hFFFFFFFF, 4'h3, 32'h0, 1);
        access(0, 0, 32'h8, 32'h0, 4'h0, 32'h0BADF00D, 0);
        access(0, 1, 32'h8, 32'h0, 4'h0, 32'h0BADF00D, 0);
        access(0, 0, 32'h3FFC, 32'hA5A55A5A, 4'hF, 32'h0, 0);
        access(0, 0, 32'h3FFF, 32'h0, 4'h0, 32'hA5A55A5A, 0);
        access(0, 0, 32'hFFFFFFFC, 32'h0, 4'h0, 32'h0, 1);

        // Instance 1: zero wait states, non-zero base
        for (int j = 0; j < 3; j++) access(1, 0, b2b_addr[j], b2b_data[j], 4'hF, 32'h0, 0);
        access(1, 0, 32'h0FFC, 32'h0, 4'h0, 32'h0, 1);
        access(1, 0, 32'h2000, 32'h0, 4'h0, 32'h0, 1);

        base = resp_count[1];
        @(negedge clk);
        valid[1] = 1'b1;
        instr[1] = 1'b0;
        wstrb[1] = 4'h0;
        wdata[1] = 32'h0;
        addr[1]  = b2b_addr[0];
        for (int j = 0; j < 3; j++) begin
            @(posedge clk);
            #1;
            push(1, b2b_data[j], 0);
            start = resp_count[1];
            for (int i = 0; i < 10 && resp_count[1] == start; i++) @(posedge clk);
            #1;
            chk("b2b_response_seen", 32'(resp_count[1] - start), 32'd1);
            t[j] = resp_cyc[1];
            if (j < 2) addr[1] = b2b_addr[j+1];
            else       valid[1] = 1'b0;
        end
        chk("b2b_gap1", 32'(t[1] - t[0]), 32'd2);
        chk("b2b_gap2", 32'(t[2] - t[1]), 32'd2);
        repeat (6) @(posedge clk);
        chk("b2b_total", 32'(resp_count[1] - base), 32'd3);

        // Instance 2: reset while waiting discards the uncommitted write
        access(2, 0, 32'h40, 32'h11111111, 4'hF, 32'h0, 0);
        base = resp_count[2];
        @(negedge clk);
        valid[2] = 1'b1;
        instr[2] = 1'b0;
        addr[2]  = 32'h40;
        wdata[2] = 32'h22222222;
        wstrb[2] = 4'hF;
        @(posedge clk);
        #1;
        valid[2] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst[2] = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", 32'(rdy[2]), 32'h0);
        chk("rst_mid_rdata", rdat[2], 32'h0);
        chk("rst_mid_error", 32'(errs[2]), 32'h0);
        rst[2] = 1'b1;
        repeat (8) @(negedge clk);
        chk("rst_mid_no_pulse", 32'(resp_count[2] - base), 32'd0);
        access(2, 0, 32'h40, 32'h0, 4'h0, 32'h11111111, 0);
        access(2, 0, 32'h40, 32'hAB0000CD, 4'b1001, 32'h0, 0);
        access(2, 0, 32'h41, 32'h0, 4'h0, 32'hAB1111CD, 0);
        access(2, 0, 32'h400, 32'h0, 4'h0, 32'h0, 1);

        repeat (5) @(posedge clk);
        chk("queues_drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
